// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared state encoding and default sizes for the memory block sequencer
package mem_seq_pkg;

  localparam int DEF_SIZE    = 5;
  localparam int DEF_MEMSIZE = 25;
  localparam int DEF_ROUNDS  = 24;
  localparam int DEF_RW      = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FIRST,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mem_block_sequencer_if.sv
// rtl/mem_block_sequencer_if.sv - start/done handshake and memory block controls; abort exists with MEM_SEQ_ABORT_EN
interface mem_block_sequencer_if
  import mem_seq_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int RW   = DEF_RW
);

  logic            start;
`ifdef MEM_SEQ_ABORT_EN
  logic            abort;
`endif
  logic            init;
  logic            firstread;
  logic            read;
  logic            write;
  logic [SIZE-1:0] index;
  logic [RW-1:0]   round;
  logic            busy;
  logic            done;

`ifdef MEM_SEQ_ABORT_EN
  modport master (output start, output abort,
                  input init, input firstread, input read, input write,
                  input index, input round, input busy, input done);
  modport slave  (input start, input abort,
                  output init, output firstread, output read, output write,
                  output index, output round, output busy, output done);
`else
  modport master (output start,
                  input init, input firstread, input read, input write,
                  input index, input round, input busy, input done);
  modport slave  (input start,
                  output init, output firstread, output read, output write,
                  output index, output round, output busy, output done);
`endif

endinterface

// File: rtl/mem_seq_counter.sv
// rtl/mem_seq_counter.sv - nested cell-index / round counter with clear, increment and last flags
module mem_seq_counter
  import mem_seq_pkg::*;
#(
  parameter int SIZE    = DEF_SIZE,
  parameter int MEMSIZE = DEF_MEMSIZE,
  parameter int ROUNDS  = DEF_ROUNDS,
  parameter int RW      = DEF_RW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_inc,
  output logic [SIZE-1:0] o_index,
  output logic [RW-1:0]   o_round,
  output logic            o_last_index,
  output logic            o_last_round
);

  localparam logic [SIZE-1:0] LAST_INDEX = SIZE'(MEMSIZE - 1);
  localparam logic [RW-1:0]   LAST_ROUND = RW'(ROUNDS - 1);

  logic [SIZE-1:0] r_index;
  logic [RW-1:0]   r_round;

  // At the very last cell of the last round the counters hold, so index never passes MEMSIZE-1.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_index <= '0;
      r_round <= '0;
    end else if (i_inc) begin
      if (!o_last_index) begin
        r_index <= r_index + SIZE'(1);
      end else if (!o_last_round) begin
        r_index <= '0;
        r_round <= r_round + RW'(1);
      end
    end
  end

  assign o_index      = r_index;
  assign o_round      = r_round;
  assign o_last_index = (r_index == LAST_INDEX);
  assign o_last_round = (r_round == LAST_ROUND);

endmodule

// File: rtl/mem_block_sequencer.sv
// rtl/mem_block_sequencer.sv - load/first-read/read-write sweep FSM for one memory block; MEM_SEQ_ABORT_EN adds abort
module mem_block_sequencer
  import mem_seq_pkg::*;
#(
  parameter int SIZE    = DEF_SIZE,
  parameter int MEMSIZE = DEF_MEMSIZE,
  parameter int ROUNDS  = DEF_ROUNDS,
  parameter int RW      = DEF_RW
) (
  input logic                  clk,
  input logic                  rst,
  mem_block_sequencer_if.slave bus
);

  state_e          r_state;
  state_e          w_next;
  logic            w_clr;
  logic            w_inc;
  logic            w_last_index;
  logic            w_last_round;
  logic [SIZE-1:0] w_index;
  logic [RW-1:0]   w_round;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = bus.start ? ST_LOAD : ST_IDLE;
      ST_LOAD:  w_next = ST_FIRST;
      ST_FIRST: w_next = ST_READ;
      ST_READ:  w_next = ST_WRITE;
      ST_WRITE: begin
        if (!w_last_index) begin
          w_next = ST_READ;
        end else if (!w_last_round) begin
          w_next = ST_FIRST;
        end else begin
          w_next = ST_DONE;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
`ifdef MEM_SEQ_ABORT_EN
    if (bus.abort && (r_state != ST_IDLE)) begin
      w_next = ST_IDLE;
    end
`endif
  end

  // Counters clear on every entry into IDLE, so DONE still shows the final index/round.
  assign w_clr = (w_next == ST_IDLE);
  assign w_inc = (r_state == ST_WRITE);

  mem_seq_counter #(
    .SIZE    (SIZE),
    .MEMSIZE (MEMSIZE),
    .ROUNDS  (ROUNDS),
    .RW      (RW)
  ) u_counter (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_clr),
    .i_inc        (w_inc),
    .o_index      (w_index),
    .o_round      (w_round),
    .o_last_index (w_last_index),
    .o_last_round (w_last_round)
  );

  assign bus.init      = (r_state == ST_LOAD);
  assign bus.firstread = (r_state == ST_FIRST);
  assign bus.read      = (r_state == ST_READ);
  assign bus.write     = (r_state == ST_WRITE);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.index     = w_index;
  assign bus.round     = w_round;

endmodule

// File: tb/tb_mem_block_sequencer.sv
// tb/tb_mem_block_sequencer.sv - vector table and directed sequences for mem_block_sequencer
module tb_mem_block_sequencer;
  import mem_seq_pkg::*;

  typedef struct packed {
    logic                init;
    logic                firstread;
    logic                read;
    logic                write;
    logic                busy;
    logic                done;
    logic [DEF_SIZE-1:0] index;
  } obs_t;

  typedef struct {
    logic start;
    logic rst;
    obs_t exp;
  } vec_t;

  localparam int NV = 120;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   vectors = 0;
  int   miscompares = 0;
  vec_t vecs [1:NV];

  always #5 clk = ~clk;

  mem_block_sequencer_if #(.SIZE(DEF_SIZE), .RW(DEF_RW)) bus_a ();
  mem_block_sequencer_if #(.SIZE(DEF_SIZE), .RW(DEF_RW)) bus_b ();

  mem_block_sequencer #(
    .SIZE(DEF_SIZE), .MEMSIZE(DEF_MEMSIZE), .ROUNDS(1), .RW(DEF_RW)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  mem_block_sequencer #(
    .SIZE(DEF_SIZE), .MEMSIZE(DEF_MEMSIZE), .ROUNDS(DEF_ROUNDS), .RW(DEF_RW)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected outputs d cycles after LOAD of a single-round run.
  function automatic obs_t run_exp(input int d);
    obs_t o;
    int   j;
    o = '0;
    o.busy = 1'b1;
    if (d == 0) begin
      o.init = 1'b1;
    end else if (d == 1) begin
      o.firstread = 1'b1;
    end else if (d <= 51) begin
      j = d - 2;
      if (j % 2 == 0) o.read = 1'b1;
      else            o.write = 1'b1;
      o.index = DEF_SIZE'(j / 2);
    end else begin
      o.done  = 1'b1;
      o.index = DEF_SIZE'(DEF_MEMSIZE - 1);
    end
    return o;
  endfunction

  function automatic obs_t exp_at(input int c);
    if (c >= 1 && c <= 53) return run_exp(c - 1);
    if (c >= 55 && c <= 82) return run_exp(c - 55);
    return '0;
  endfunction

  function automatic obs_t sample_a();
    obs_t o;
    o = {bus_a.init, bus_a.firstread, bus_a.read, bus_a.write, bus_a.busy, bus_a.done, bus_a.index};
    return o;
  endfunction

  always @(negedge clk) begin
    if (!$onehot0({bus_a.init, bus_a.firstread, bus_a.read, bus_a.write})) begin
      miscompares++;
      $display("FAIL strobe_excl_a: strobes %b expected at most one high",
               {bus_a.init, bus_a.firstread, bus_a.read, bus_a.write});
    end
    if (!$onehot0({bus_b.init, bus_b.firstread, bus_b.read, bus_b.write})) begin
      miscompares++;
      $display("FAIL strobe_excl_b: strobes %b expected at most one high",
               {bus_b.init, bus_b.firstread, bus_b.read, bus_b.write});
    end
  end

  initial begin
    obs_t o;
    int   done_cyc;
    int   fr_cnt;
    int   last_fr;

    // Start pulses at 10/40 are ignored; start held 50..56 relaunches at 55; rst during WRITE index 12.
    for (int c = 1; c <= NV; c++) begin
      vecs[c].start = (c == 10) || (c == 40) || (c >= 50 && c <= 56);
      vecs[c].rst   = (c == 82);
      vecs[c].exp   = exp_at(c);
    end

    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.start = 1'b1;
    bus_b.start = 1'b0;
`ifdef MEM_SEQ_ABORT_EN
    bus_a.abort = 1'b0;
    bus_b.abort = 1'b0;
`endif
    tick();
    tick();
    check("reset_outputs", int'(sample_a()), 0);
    check("reset_round", int'(bus_a.round), 0);

    rst_a = 1'b0;
    tick();
    for (int c = 1; c <= NV; c++) begin
      o = sample_a();
      if (o !== vecs[c].exp) begin
        miscompares++;
        $display("FAIL vec_cycle_%0d: got %b expected %b", c, o, vecs[c].exp);
      end
      vectors++;
      bus_a.start = vecs[c].start;
      rst_a       = vecs[c].rst;
      tick();
    end
    bus_a.start = 1'b0;
    rst_a = 1'b0;

    // Full default run on dut_b.
    rst_b = 1'b0;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    done_cyc = -1;
    fr_cnt = 0;
    last_fr = -1;
    for (int c = 1; c <= 1400 && done_cyc < 0; c++) begin
      if (bus_b.firstread) begin
        check("b_round_at_first", int'(bus_b.round), fr_cnt);
        check("b_first_index", int'(bus_b.index), 0);
        if (last_fr >= 0) check("b_first_spacing", c - last_fr, 51);
        last_fr = c;
        fr_cnt++;
      end
      if (bus_b.done) done_cyc = c;
      tick();
    end
    check("b_done_cycle", done_cyc, 1226);
    check("b_firstread_count", fr_cnt, 24);
    check("b_busy_after_done", int'(bus_b.busy), 0);

`ifdef MEM_SEQ_ABORT_EN
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    check("abort_busy_c20", int'(bus_a.busy), 1);
    bus_a.abort = 1'b1;
    tick();
    bus_a.abort = 1'b0;
    check("abort_outputs_c21", int'(sample_a()), 0);
    done_cyc = -1;
    for (int c = 0; c < 40; c++) begin
      if (bus_a.done || bus_a.busy) done_cyc = c;
      tick();
    end
    check("abort_no_done", done_cyc, -1);
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= 100 && done_cyc < 0; c++) begin
      if (bus_a.done) done_cyc = c;
      else tick();
    end
    check("abort_restart_done", done_cyc, 53);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
